// File: rtl/variable_clock_gen_if.sv
// -----------------------------------------------------------------------------
// variable_clock_gen_if
//   Control/status bundle between the debug/button logic and the clock-enable
//   generator.
//   master : drives speed_sel, speed_load, jump, pause, step;
//            observes tick, current_limit, target_idx, locked.
//   slave  : the generator (direction reversed).
// -----------------------------------------------------------------------------
interface variable_clock_gen_if #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 32
);
  logic [SEL_W-1:0] speed_sel;
  logic             speed_load;
  logic             jump;
  logic             pause;
  logic             step;
  logic             tick;
  logic [CNT_W-1:0] current_limit;
  logic [SEL_W-1:0] target_idx;
  logic             locked;

  modport master (
    output speed_sel, speed_load, jump, pause, step,
    input  tick, current_limit, target_idx, locked
  );

  modport slave (
    input  speed_sel, speed_load, jump, pause, step,
    output tick, current_limit, target_idx, locked
  );
endinterface

// File: rtl/variable_clock_gen.sv
// -----------------------------------------------------------------------------
// variable_clock_gen
//   Clock-enable generator for the CPU domain. Emits a registered 1-cycle
//   tick every current_limit+1 clk cycles. current_limit glides toward the
//   targeted table entry by halving/doubling once per 2**GLIDE_W cycles, or
//   jumps straight to it on request. Pause freezes the period counter; a
//   step strobe while paused issues one tick.
//   Ports:
//     clk  : system clock
//     rst  : synchronous, active-low reset
//     bus  : variable_clock_gen_if.slave
//            (speed_sel, speed_load, jump, pause, step in;
//             tick, current_limit, target_idx, locked out)
// -----------------------------------------------------------------------------
module variable_clock_gen #(
  parameter int                            NUM_SPEEDS  = 3,
  parameter int                            CNT_W       = 32,
  parameter int                            GLIDE_W     = 25,
  parameter logic [NUM_SPEEDS*CNT_W-1:0]   LIMITS      = {32'd16, 32'd32_768, 32'd4_194_304},
  parameter int                            DEFAULT_SEL = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  variable_clock_gen_if.slave  bus
);

  localparam int SEL_W = $clog2(NUM_SPEEDS);

  // Table lookup: entry i occupies LIMITS[i*CNT_W +: CNT_W].
  function automatic logic [CNT_W-1:0] limit_of(input logic [SEL_W-1:0] idx);
    return LIMITS[int'(idx)*CNT_W +: CNT_W];
  endfunction

  localparam logic [SEL_W-1:0] DEFAULT_IDX   = SEL_W'(DEFAULT_SEL);
  localparam logic [CNT_W-1:0] DEFAULT_LIMIT = LIMITS[DEFAULT_SEL*CNT_W +: CNT_W];

  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [CNT_W-1:0]   cur_q,   cur_d;
  logic [SEL_W-1:0]   tgt_q,   tgt_d;
  logic [GLIDE_W-1:0] glide_q, glide_d;
  logic               tick_q,  tick_d;

  logic [CNT_W-1:0]   tgt_limit;
  logic               locked;
  logic               load_valid;
  logic               glide_step;
  logic [CNT_W-1:0]   half;
  logic [CNT_W:0]     dbl;

  assign tgt_limit  = limit_of(tgt_q);
  assign locked     = (cur_q == tgt_limit);
  assign load_valid = bus.speed_load && (int'(bus.speed_sel) < NUM_SPEEDS);
  assign glide_step = (&glide_q) && !locked;

  // Doubling is done one bit wider so it saturates against the target
  // instead of wrapping.
  assign half = cur_q >> 1;
  assign dbl  = (cur_q == '0) ? {{CNT_W{1'b0}}, 1'b1} : {cur_q, 1'b0};

  // NOTE: every signal assigned here gets a default first so no latch is
  // inferred on paths that leave it untouched.
  always_comb begin
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    glide_d = glide_q + 1'b1;

    // Period counter; >= lets a shrunken limit take effect on the next cycle.
    if (bus.pause) begin
      if (bus.step) begin
        tick_d = 1'b1;
        cnt_d  = '0;
      end
    end else if (cnt_q >= cur_q) begin
      tick_d = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Glide step uses the old target; a same-edge load only retargets.
    if (glide_step) begin
      if (tgt_limit < cur_q) begin
        cur_d = (half > tgt_limit) ? half : tgt_limit;
      end else begin
        cur_d = (dbl > {1'b0, tgt_limit}) ? tgt_limit : dbl[CNT_W-1:0];
      end
    end

    // A jumping load overrides any glide step on the same edge.
    if (load_valid) begin
      tgt_d = bus.speed_sel;
      if (bus.jump) begin
        cur_d = limit_of(bus.speed_sel);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      cur_q   <= DEFAULT_LIMIT;
      tgt_q   <= DEFAULT_IDX;
      glide_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      glide_q <= glide_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.tick          = tick_q;
  assign bus.current_limit = cur_q;
  assign bus.target_idx    = tgt_q;
  assign bus.locked        = locked;

endmodule

// File: tb/tb_variable_clock_gen.sv
// -----------------------------------------------------------------------------
// tb_variable_clock_gen
//   Self-checking bench: a behavioural model tracks the expected outputs
//   cycle by cycle from integer arithmetic, a compare process checks every
//   cycle, and directed scenarios pin literal values.
// -----------------------------------------------------------------------------
module tb_variable_clock_gen;

  localparam int NUM_SPEEDS   = 3;
  localparam int CNT_W        = 8;
  localparam int GLIDE_W      = 3;
  localparam int SEL_W        = 2;
  localparam int GLIDE_PERIOD = 1 << GLIDE_W;

  // Entry 0 sits in the low bits: table = {32, 8, 2}.
  int lim_tab [NUM_SPEEDS] = '{32, 8, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;

  variable_clock_gen_if #(.SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

  variable_clock_gen #(
    .NUM_SPEEDS (NUM_SPEEDS),
    .CNT_W      (CNT_W),
    .GLIDE_W    (GLIDE_W),
    .LIMITS     ({8'd2, 8'd8, 8'd32}),
    .DEFAULT_SEL(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt, m_cur, m_tgt, m_cycles, m_next, m_tl;
  bit m_tick;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_cnt = 0; m_cur = lim_tab[0]; m_tgt = 0; m_tick = 0; m_cycles = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (bus.pause) begin
        m_tick = bus.step;
        if (bus.step) m_cnt = 0;
      end else if (m_cnt >= m_cur) begin
        m_tick = 1; m_cnt = 0;
      end else begin
        m_tick = 0; m_cnt = m_cnt + 1;
      end
      m_next = m_cur;
      m_tl   = lim_tab[m_tgt];
      if ((m_cycles % GLIDE_PERIOD) == GLIDE_PERIOD - 1 && m_cur != m_tl) begin
        if (m_tl < m_cur) m_next = (m_cur / 2 > m_tl) ? m_cur / 2 : m_tl;
        else              m_next = ((m_cur == 0 ? 1 : m_cur * 2) < m_tl) ? (m_cur == 0 ? 1 : m_cur * 2) : m_tl;
      end
      if (bus.speed_load && int'(bus.speed_sel) < NUM_SPEEDS) begin
        m_tgt = int'(bus.speed_sel);
        if (bus.jump) m_next = lim_tab[m_tgt];
      end
      m_cur = m_next;
      m_cycles++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("tick",          32'(bus.tick),          32'(m_tick));
      check("current_limit", 32'(bus.current_limit), 32'(m_cur));
      check("target_idx",    32'(bus.target_idx),    32'(m_tgt));
      check("locked",        32'(bus.locked),        32'(m_cur == lim_tab[m_tgt]));
    end
  end

  // ---------------- directed helpers ----------------
  // Negedges until tick is seen; -1 if the bound expires.
  task automatic wait_tick(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tick && n < bound);
    if (!bus.tick) n = -1;
  endtask

  task automatic load(input int sel, input bit jmp);
    @(negedge clk);
    bus.speed_load = 1'b1;
    bus.speed_sel  = SEL_W'(sel);
    bus.jump       = jmp;
    @(negedge clk);
    bus.speed_load = 1'b0;
    bus.jump       = 1'b0;
  endtask

  int n, ticks, k;
  int chg_val [4];
  int chg_cyc [4];
  int prev;

  initial begin
    bus.speed_sel = '0; bus.speed_load = 1'b0; bus.jump = 1'b0;
    bus.pause = 1'b0;   bus.step = 1'b0;

    // 1: reset and steady period of 33 cycles
    repeat (2) @(negedge clk);
    check("rst_limit",  32'(bus.current_limit), 32);
    check("rst_locked", 32'(bus.locked), 1);
    check("rst_tick",   32'(bus.tick), 0);
    rst = 1'b1;
    wait_tick(100, n);
    check("first_tick_gap", n, 33);
    wait_tick(100, n);
    check("tick_gap", n, 33);

    // 2: glide down 32->16->8->4->2, one step per 8 cycles
    load(2, 1'b0);
    check("glide_unlocked", 32'(bus.locked), 0);
    k = 0; prev = int'(bus.current_limit);
    for (int c = 0; c < 80 && k < 4; c++) begin
      @(negedge clk);
      if (int'(bus.current_limit) != prev) begin
        chg_val[k] = int'(bus.current_limit);
        chg_cyc[k] = c;
        if (k == 0) check("glide_locked_mid", 32'(bus.locked), 0);
        k++;
        prev = int'(bus.current_limit);
      end
    end
    check("glide_steps", k, 4);
    if (k == 4) begin
      check("glide_v0", chg_val[0], 16);
      check("glide_v1", chg_val[1], 8);
      check("glide_v2", chg_val[2], 4);
      check("glide_v3", chg_val[3], 2);
      for (int i = 1; i < 4; i++) check("glide_interval", chg_cyc[i] - chg_cyc[i-1], 8);
    end
    check("glide_locked_end", 32'(bus.locked), 1);

    // 3: jump to entry 1 (limit 8)
    load(1, 1'b1);
    check("jump_limit",  32'(bus.current_limit), 8);
    check("jump_locked", 32'(bus.locked), 1);
    repeat (10) @(negedge clk);
    check("jump_stable", 32'(bus.current_limit), 8);

    // 5: pause, step, resume
    bus.pause = 1'b1;
    ticks = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tick) ticks++;
    end
    check("pause_no_ticks", ticks, 0);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    check("step_tick", 32'(bus.tick), 1);
    bus.pause = 1'b0;
    wait_tick(100, n);
    check("resume_gap", n, 9);

    // 4: glide up toward 32 with an invalid load in the middle
    load(0, 1'b0);
    n = 0;
    while (bus.current_limit != 8'd16 && n < 20) begin @(negedge clk); n++; end
    check("glide_up_mid", 32'(bus.current_limit), 16);
    load(3, 1'b1);
    check("invalid_target", 32'(bus.target_idx), 0);
    check("invalid_limit",  32'(bus.current_limit), 16);
    n = 0;
    while (!bus.locked && n < 30) begin @(negedge clk); n++; end
    check("glide_up_end", 32'(bus.current_limit), 32);

    // 6: reset mid-glide at limit 8 heading to 32
    load(1, 1'b1);
    load(0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_limit",  32'(bus.current_limit), 32);
    check("midrst_target", 32'(bus.target_idx), 0);
    check("midrst_tick",   32'(bus.tick), 0);
    check("midrst_locked", 32'(bus.locked), 1);
    rst = 1'b1;

    // Randomized traffic; the compare process checks every cycle.
    repeat (3000) begin
      @(negedge clk);
      rst            = ($urandom_range(0, 199) != 0);
      bus.speed_load = ($urandom_range(0, 15) == 0);
      bus.speed_sel  = SEL_W'($urandom_range(0, 3));
      bus.jump       = $urandom_range(0, 1);
      if ($urandom_range(0, 31) == 0) bus.pause = ~bus.pause;
      bus.step       = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    rst = 1'b1; bus.speed_load = 1'b0; bus.step = 1'b0; bus.pause = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
